eth_rx_frame_checker: RTL

Receive-side checker for the switch's byte-wide GMII-style port (clk, dv, er, data[7:0]), the consumer of the frame stream produced by the port frame generators. It strips preamble/SFD, measures length, and checks the Ethernet FCS. It extracts destination port (DA byte 5) and sequence number (last byte before FCS), then reports one status pulse per frame. It is used on switch egress ports and as a self-checking bench monitor.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/eth_rx_fcs_check.sv | 67 ++++++
 rtl/eth_rx_frame_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: receive FSM states, framing constants and the
// byte-wise CRC32 update used by both the frame generators and the checker.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    BODY,
    DROP
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  // MSB-first register fed LSB-first: bit 31 holds the first FCS bit on the wire
  function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_check.sv
// Four-byte delay line ahead of the CRC so the trailing FCS is never folded in;
// compares the held FCS against the running CRC and exposes the last pre-FCS byte.
module eth_rx_fcs_check
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [7:0] data,
  output logic       crc_ok,
  output logic [7:0] seq_byte
);

  logic [3:0][7:0] dl_q, dl_d;
  logic [2:0]      fill_q, fill_d;
  logic [31:0]     crc_q, crc_d;
  logic [7:0]      seq_q, seq_d;

  always_comb begin
    dl_d   = dl_q;
    fill_d = fill_q;
    crc_d  = crc_q;
    seq_d  = seq_q;
    if (clear) begin
      dl_d   = '0;
      fill_d = 3'd0;
      crc_d  = CRC_INIT;
      seq_d  = 8'h00;
    end else if (byte_en) begin
      dl_d = {dl_q[2:0], data};
      if (fill_q == 3'd4) begin
        crc_d = eth_crc32_8d(crc_q, dl_q[3]);
        seq_d = dl_q[3];
      end else begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q   <= '0;
      fill_q <= 3'd0;
      crc_q  <= CRC_INIT;
      seq_q  <= 8'h00;
    end else begin
      dl_q   <= dl_d;
      fill_q <= fill_d;
      crc_q  <= crc_d;
      seq_q  <= seq_d;
    end
  end

  // dl_q[3] is the first FCS byte; each received bit must be the complement of the CRC bit
  always_comb begin
    crc_ok = (fill_q == 3'd4);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        if (dl_q[3-j][k] == crc_q[31-8*j-k]) crc_ok = 1'b0;
      end
    end
  end

  assign seq_byte = seq_q;

endmodule

// File: rtl/eth_rx_frame_checker.sv
// GMII-style receive frame checker: strips preamble/SFD, measures, checks FCS and
// reports one status pulse per frame. ETH_RX_STATS_EN builds the good/bad counters.
module eth_rx_frame_checker
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv,
  input  logic             er,
  input  logic [7:0]       data,
  output logic             frame_valid,
  output logic             crc_ok,
  output logic             len_err,
  output logic             phy_err,
  output logic [1:0]       dst_port,
  output logic [7:0]       seq_num,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  rx_state_t        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_q, phy_d;
  logic [1:0]       dst_q, dst_d;
  logic             fcs_clear, fcs_byte_en, fcs_ok;
  logic [7:0]       fcs_seq;
  logic             report;
  logic             rpt_crc_ok, rpt_len_err;

  logic             frame_valid_q, crc_ok_q, len_err_q, phy_err_q, busy_q;
  logic [1:0]       dst_port_q;
  logic [7:0]       seq_num_q;
  logic [LEN_W-1:0] frame_len_q;

  eth_rx_fcs_check u_fcs (
    .clk      (clk),
    .rst      (rst),
    .clear    (fcs_clear),
    .byte_en  (fcs_byte_en),
    .data     (data),
    .crc_ok   (fcs_ok),
    .seq_byte (fcs_seq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      phy_q   <= 1'b0;
      dst_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      phy_q   <= phy_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    phy_d       = phy_q;
    dst_d       = dst_q;
    fcs_clear   = 1'b0;
    fcs_byte_en = 1'b0;
    report      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv) state_d = (data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (data == SFD_BYTE) begin
          state_d   = BODY;
          fcs_clear = 1'b1;
          len_d     = '0;
          phy_d     = 1'b0;
          dst_d     = 2'b00;
        end else if (data != PREAMBLE_BYTE) begin
          state_d = DROP;
        end
      end
      BODY: begin
        if (dv) begin
          fcs_byte_en = 1'b1;
          if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
          if (er) phy_d = 1'b1;
          if (len_q == LEN_W'(5)) dst_d = data[1:0];
        end else begin
          state_d = IDLE;
          report  = 1'b1;
        end
      end
      DROP: begin
        if (!dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rpt_crc_ok  = fcs_ok && (len_q >= LEN_W'(4));
  assign rpt_len_err = (len_q < LEN_MIN) || (len_q > LEN_MAX);

  // Status registers update only on a report and hold until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      len_err_q     <= 1'b0;
      phy_err_q     <= 1'b0;
      dst_port_q    <= 2'b00;
      seq_num_q     <= 8'h00;
      frame_len_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= report;
      busy_q        <= (state_d != IDLE);
      if (report) begin
        crc_ok_q    <= rpt_crc_ok;
        len_err_q   <= rpt_len_err;
        phy_err_q   <= phy_q;
        dst_port_q  <= dst_q;
        seq_num_q   <= fcs_seq;
        frame_len_q <= len_q;
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign crc_ok      = crc_ok_q;
  assign len_err     = len_err_q;
  assign phy_err     = phy_err_q;
  assign dst_port    = dst_port_q;
  assign seq_num     = seq_num_q;
  assign frame_len   = frame_len_q;
  assign busy        = busy_q;

`ifdef ETH_RX_STATS_EN
  logic [CNT_W-1:0] good_q, bad_q;
  logic             rpt_good;

  assign rpt_good = rpt_crc_ok && !rpt_len_err && !phy_q;

  // Counted on the same edge as the status update so both appear together
  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (report) begin
      if (rpt_good && (good_q != '1)) good_q <= good_q + CNT_W'(1);
      if (!rpt_good && (bad_q != '1)) bad_q <= bad_q + CNT_W'(1);
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule
